// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, blanking, sync, field and raster position.
// Every output is a register that updates on the pixel-divider wrap edge, so all flags stay coherent.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 58,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 16,
  parameter int unsigned CE_DIV   = 4,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          interlace_en,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          h_blank,
  output logic          v_blank,
  output logic          h_sync,
  output logic          v_sync,
  output logic          field,
  output logic          interlaced,
  output logic          frame_start
);

  localparam int unsigned DW  = $clog2(CE_DIV);
  localparam int unsigned HXW = HW + 1;
  localparam int unsigned VS0 = V_ACTIVE + V_FP;

  localparam logic [DW-1:0]  DIV_LAST   = DW'(CE_DIV - 1);
  localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
  // Horizontal thresholds carry one spare bit so a sync ending at H_TOTAL still fits
  localparam logic [HXW-1:0] H_HALF     = HXW'(H_TOTAL / 2);
  localparam logic [HXW-1:0] HB_START   = HXW'(H_ACTIVE);
  localparam logic [HXW-1:0] HS_START   = HXW'(H_ACTIVE + H_FP);
  localparam logic [HXW-1:0] HS_END     = HXW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST_ODD = VW'(V_TOTAL);
  localparam logic [VW-1:0]  VB_START   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_START   = VW'(VS0);
  localparam logic [VW-1:0]  VS_END     = VW'(VS0 + V_SYNC);

  // Encoding is {interlaced, field} so the outputs come straight off the state bits
  typedef enum logic [1:0] {
    MODE_PROG = 2'b00,
    MODE_EVEN = 2'b10,
    MODE_ODD  = 2'b11
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [DW-1:0] div_q, div_d;
  logic          run_q, run_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          ce_q, ce_d;
  logic          fs_q, fs_d;
  logic          hb_q, hb_d;
  logic          vb_q, vb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  logic           wrap;
  logic           eol;
  logic           eof;
  logic [VW-1:0]  lt_last;
  logic [HXW-1:0] h_ext;
  logic           hs_act;
  logic           vs_nom;
  logic           vs_odd;
  logic           vs_act;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_PROG;
      div_q  <= '0;
      run_q  <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      ce_q   <= 1'b0;
      fs_q   <= 1'b0;
      hb_q   <= 1'b1;
      vb_q   <= 1'b1;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      run_q  <= run_d;
      h_q    <= h_d;
      v_q    <= v_d;
      ce_q   <= ce_d;
      fs_q   <= fs_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  // Next-state: divider, raster advance, field/mode update and decoded flags
  always_comb begin
    mode_d  = mode_q;
    div_d   = div_q;
    run_d   = run_q;
    h_d     = h_q;
    v_d     = v_q;
    ce_d    = 1'b0;
    fs_d    = 1'b0;
    hb_d    = hb_q;
    vb_d    = vb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    h_ext   = '0;
    hs_act  = 1'b0;
    vs_nom  = 1'b0;
    vs_odd  = 1'b0;
    vs_act  = 1'b0;

    wrap    = (div_q == DIV_LAST);
    lt_last = (mode_q == MODE_ODD) ? V_LAST_ODD : V_LAST;
    eol     = (h_q == H_LAST);
    eof     = eol && (v_q == lt_last);

    div_d = wrap ? '0 : div_q + 1'b1;

    if (wrap) begin
      ce_d  = 1'b1;
      run_d = 1'b1;
      // The first wrap after reset presents (0,0) rather than advancing past it
      if (run_q) begin
        if (eol) begin
          h_d = '0;
          v_d = eof ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (eof) begin
          if (interlace_en) begin
            mode_d = (mode_q == MODE_ODD) ? MODE_EVEN : MODE_ODD;
          end else begin
            mode_d = MODE_PROG;
          end
        end
      end

      h_ext  = {1'b0, h_d};
      hb_d   = (h_ext >= HB_START);
      vb_d   = (v_d >= VB_START);
      hs_act = (h_ext >= HS_START) && (h_ext < HS_END);
      vs_nom = (v_d >= VS_START) && (v_d < VS_END);
      // Odd interlaced field: sync edges move to mid-line
      vs_odd = ((v_d > VS_START) || ((v_d == VS_START) && (h_ext >= H_HALF))) &&
               ((v_d < VS_END)   || ((v_d == VS_END)   && (h_ext <  H_HALF)));
      vs_act = (mode_d == MODE_ODD) ? vs_odd : vs_nom;
      hs_d   = HS_POL ? hs_act : ~hs_act;
      vs_d   = VS_POL ? vs_act : ~vs_act;
      fs_d   = (h_d == '0) && (v_d == '0);
    end
  end

  assign ce_pix      = ce_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign h_blank     = hb_q;
  assign v_blank     = vb_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign field       = mode_q[0];
  assign interlaced  = mode_q[1];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 16x11 raster, CE_DIV=3, v_sync active-low.
module tb_video_timing_gen;

  localparam int unsigned CE  = 3;
  localparam int unsigned HT  = 16;
  localparam int unsigned VT  = 11;
  localparam int unsigned HW  = 4;
  localparam int unsigned VW  = 4;
  localparam bit          VSP = 1'b0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          interlace_en = 1'b0;
  logic          ce_pix;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_blank, v_blank, h_sync, v_sync, field, interlaced, frame_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CE_DIV(CE), .HS_POL(1'b1), .VS_POL(VSP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .interlace_en(interlace_en),
    .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .h_blank(h_blank), .v_blank(v_blank), .h_sync(h_sync), .v_sync(v_sync),
    .field(field), .interlaced(interlaced), .frame_start(frame_start)
  );

  typedef struct {
    int p;
    bit en;
    int h;
    int v;
    bit hb, vb, hs, vs, fs, fld, il;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int pk(input int h, input int v, input bit hb, input bit vb,
                            input bit hs, input bit vs, input bit fs, input bit fl, input bit il);
    return (h << 16) | (v << 8) | 32'({hb, vb, hs, vs, fs, fl, il});
  endfunction

  function automatic int dut_pk();
    return pk(32'(hcount), 32'(vcount), h_blank, v_blank, h_sync, v_sync,
              frame_start, field, interlaced);
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic abort(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
    finish_run();
  endtask

  task automatic next_ce(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4 * int'(CE); n++) begin
      @(posedge clk);
      #1;
      if (ce_pix) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic latency(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ce_pix && n < 20);
  endtask

  // Starts on a frame_start cycle, runs to the next one, reports length, mode and v_sync edges
  task automatic run_field(input int dv, output int clks, output int fl, output int il,
                           output int von_v, output int von_h, output int voff_v, output int voff_h);
    bit prev;
    fl = int'(field);
    il = int'(interlaced);
    von_v = -1; von_h = -1; voff_v = -1; voff_h = -1;
    prev = (v_sync == VSP);
    clks = 0;
    while (clks < 2000) begin
      @(posedge clk);
      #1;
      clks++;
      if (frame_start) break;
      if (ce_pix) begin
        if (!prev && (v_sync == VSP)) begin von_v = int'(vcount); von_h = int'(hcount); end
        if (prev && (v_sync != VSP))  begin voff_v = int'(vcount); voff_h = int'(hcount); end
        prev = (v_sync == VSP);
        if (dv >= 0 && int'(vcount) == dv && hcount == '0) interlace_en = 1'b0;
      end
    end
    if (!frame_start) abort("field_end_wait");
  endtask

  int  pix;
  int  n;
  bit  ok;
  int  clks, fl, il, von_v, von_h, voff_v, voff_h;

  task automatic field_chk(input string tag, input int dv, input int e_clks, input int e_fl,
                           input int e_il, input int e_onv, input int e_onh,
                           input int e_offv, input int e_offh, input bit chk_vs);
    run_field(dv, clks, fl, il, von_v, von_h, voff_v, voff_h);
    chk({tag, "_len"}, clks, e_clks);
    chk({tag, "_field"}, fl, e_fl);
    chk({tag, "_ilace"}, il, e_il);
    if (chk_vs) begin
      chk({tag, "_vs_on"}, (von_v << 8) | von_h, (e_onv << 8) | e_onh);
      chk({tag, "_vs_off"}, (voff_v << 8) | voff_h, (e_offv << 8) | e_offh);
    end
  endtask

  initial begin
    //          p    en h   v  hb vb hs vs fs fld il
    vecs[0]  = '{0,   0, 0,  0, 0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{7,   0, 7,  0, 0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{8,   0, 8,  0, 1, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{9,   0, 9,  0, 1, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{10,  0, 10, 0, 1, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{12,  0, 12, 0, 1, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{13,  0, 13, 0, 1, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{15,  0, 15, 0, 1, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{16,  0, 0,  1, 0, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{95,  0, 15, 5, 1, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{96,  0, 0,  6, 0, 1, 0, 1, 0, 0, 0};
    vecs[11] = '{111, 0, 15, 6, 1, 1, 0, 1, 0, 0, 0};
    vecs[12] = '{112, 0, 0,  7, 0, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{143, 0, 15, 8, 1, 1, 0, 0, 0, 0, 0};
    vecs[14] = '{144, 0, 0,  9, 0, 1, 0, 1, 0, 0, 0};
    vecs[15] = '{175, 0, 15, 10, 1, 1, 0, 1, 0, 0, 0};
    vecs[16] = '{176, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0};

    #22;
    chk("rst_ce", int'(ce_pix), 0);
    chk("rst_state", dut_pk(), pk(0, 0, 1, 1, 0, 1, 0, 0, 0));

    @(negedge clk);
    reset_n = 1'b1;
    latency(n);
    chk("first_ce_latency", n, int'(CE));

    pix = 0;
    foreach (vecs[i]) begin
      interlace_en = vecs[i].en;
      while (pix < vecs[i].p) begin
        next_ce(ok);
        if (!ok) abort("ce_wait");
        pix++;
      end
      chk($sformatf("vec%0d_p%0d", i, vecs[i].p), dut_pk(),
          pk(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].hs, vecs[i].vs,
             vecs[i].fs, vecs[i].fld, vecs[i].il));
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk("ce_one_clk", int'(ce_pix), 0);
        chk("fs_one_clk", int'(frame_start), 0);
      end
    end

    // Progressive field, then a mid-field interlace request that must wait for field end
    field_chk("progA", -1, 11 * 16 * int'(CE), 0, 0, 7, 0, 9, 0, 1'b1);
    interlace_en = 1'b1;
    field_chk("progB", -1, 11 * 16 * int'(CE), 0, 0, 7, 0, 9, 0, 1'b0);
    field_chk("oddC",  -1, 12 * 16 * int'(CE), 1, 1, 7, 8, 9, 8, 1'b1);
    field_chk("evenD", -1, 11 * 16 * int'(CE), 0, 1, 7, 0, 9, 0, 1'b1);
    field_chk("oddE",   5, 12 * 16 * int'(CE), 1, 1, 7, 8, 9, 8, 1'b0);
    chk("deassert_applied", int'(interlace_en), 0);
    field_chk("progF", -1, 11 * 16 * int'(CE), 0, 0, 7, 0, 9, 0, 1'b0);

    // Async reset in mid-frame
    n = 0;
    while (!(ce_pix && vcount == 4'd3 && hcount == 4'd5) && n < 500) begin
      next_ce(ok);
      n++;
    end
    if (n >= 500) abort("mid_pos_wait");
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ce", int'(ce_pix), 0);
    chk("mid_rst_state", dut_pk(), pk(0, 0, 1, 1, 0, 1, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    latency(n);
    chk("mid_rst_latency", n, int'(CE));
    chk("mid_rst_first_px", dut_pk(), pk(0, 0, 0, 0, 0, 1, 1, 0, 0));

    finish_run();
  end

endmodule
